// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the output-stationary systolic array.
// Latches A and B on start, clears the PEs, then streams skewed rows/columns.
module systolic_feed_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5,
    parameter int ARRAY_L    = 2,
    parameter int ARRAY_H    = 5
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           start,
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] matrix_a,
    input  logic [0:ARRAY_L-1][0:ARRAY_H-1][DATA_WIDTH-1:0] matrix_b,
    output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_feed,
    output logic [0:ARRAY_H-1][DATA_WIDTH-1:0]              b_feed,
    output logic                                           pe_clear,
    output logic                                           pe_en,
    output logic                                           busy,
    output logic                                           done
);

    localparam int N  = ARRAY_L + ARRAY_W + ARRAY_H - 2;
    localparam int SW = $clog2(N + 1);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] step;
    logic [SW-1:0] step_next;

    logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] a_lat;
    logic [0:ARRAY_L-1][0:ARRAY_H-1][DATA_WIDTH-1:0] b_lat;

    // State, step counter and operand capture on the accepting start edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            step  <= '0;
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
            if (state == IDLE && start) begin
                a_lat <= matrix_a;
                b_lat <= matrix_b;
            end
        end
    end

    // Next-state logic and control strobes decoded from the current state
    always_comb begin
        state_next = state;
        step_next  = step;
        pe_clear   = 1'b0;
        pe_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                step_next = '0;
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                pe_clear   = 1'b1;
                step_next  = '0;
                state_next = FEED;
            end
            FEED: begin
                pe_en = 1'b1;
                if (step == LAST) begin
                    step_next  = '0;
                    state_next = DONE;
                end else begin
                    step_next = step + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase
    end

    // Row i sees A[i][k] at step i+k; matching on the sum avoids negative indices
    always_comb begin
        a_feed = '0;
        if (state == FEED) begin
            for (int i = 0; i < ARRAY_W; i++) begin
                for (int k = 0; k < ARRAY_L; k++) begin
                    if (step == SW'(i + k)) begin
                        a_feed[i] = a_lat[i][k];
                    end
                end
            end
        end
    end

    // Column j sees B[k][j] at step j+k
    always_comb begin
        b_feed = '0;
        if (state == FEED) begin
            for (int j = 0; j < ARRAY_H; j++) begin
                for (int k = 0; k < ARRAY_L; k++) begin
                    if (step == SW'(j + k)) begin
                        b_feed[j] = b_lat[k][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: cycle-phase model,
// literal pins and a behavioural MAC grid for end-to-end products.
module tb_systolic_feed_ctrl;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int L  = 2;
    localparam int H  = 5;
    localparam int N  = L + W + H - 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [0:W-1][0:L-1][DW-1:0] matrix_a = '0;
    logic [0:L-1][0:H-1][DW-1:0] matrix_b = '0;
    logic [0:W-1][DW-1:0] a_feed;
    logic [0:H-1][DW-1:0] b_feed;
    logic pe_clear, pe_en, busy, done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: p = position within a run (0 = idle, 1 = clear, N+2 = done)
    int p = 0;
    int ma [W][L];
    int mb [L][H];

    // behavioural output-stationary grid
    int acc [W][H];
    int ah  [W][H];
    int bv  [W][H];

    systolic_feed_ctrl #(
        .DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L), .ARRAY_H(H)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .matrix_a(matrix_a), .matrix_b(matrix_b),
        .a_feed(a_feed), .b_feed(b_feed),
        .pe_clear(pe_clear), .pe_en(pe_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_skew();
        for (int i = 0; i < W; i++)
            for (int k = 0; k < L; k++)
                matrix_a[i][k] = DW'(10 * i + k + 1);
        for (int k = 0; k < L; k++)
            for (int j = 0; j < H; j++)
                matrix_b[k][j] = DW'(10 * k + j + 1);
    endtask

    // model update: sampled at the same edge as the DUT
    always @(posedge clk) begin
        if (!reset_n) begin
            p <= 0;
            for (int i = 0; i < W; i++)
                for (int k = 0; k < L; k++) ma[i][k] <= 0;
            for (int k = 0; k < L; k++)
                for (int j = 0; j < H; j++) mb[k][j] <= 0;
        end else if (p == 0) begin
            if (start) begin
                p <= 1;
                for (int i = 0; i < W; i++)
                    for (int k = 0; k < L; k++) ma[i][k] <= int'(matrix_a[i][k]);
                for (int k = 0; k < L; k++)
                    for (int j = 0; j < H; j++) mb[k][j] <= int'(matrix_b[k][j]);
            end
        end else if (p == N + 2) begin
            p <= 0;
        end else begin
            p <= p + 1;
        end
    end

    // compare DUT against model every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            logic [0:W-1][DW-1:0] ea;
            logic [0:H-1][DW-1:0] eb;
            bit feed;
            int t;
            feed = (p >= 2) && (p <= N + 1);
            t = p - 2;
            ea = '0;
            eb = '0;
            for (int i = 0; i < W; i++)
                if (feed && t - i >= 0 && t - i < L) ea[i] = DW'(ma[i][t - i]);
            for (int j = 0; j < H; j++)
                if (feed && t - j >= 0 && t - j < L) eb[j] = DW'(mb[t - j][j]);
            chk("m_a_feed", 64'(a_feed), 64'(ea));
            chk("m_b_feed", 64'(b_feed), 64'(eb));
            chk("m_ctrl", 64'({pe_clear, pe_en, busy, done}),
                64'({p == 1, feed, p != 0, p == N + 2}));
        end
    end

    // MAC grid advances at the end of each enabled cycle
    always @(negedge clk) begin
        int ain, bin;
        if (pe_clear) begin
            for (int i = 0; i < W; i++)
                for (int j = 0; j < H; j++) begin
                    acc[i][j] <= 0;
                    ah[i][j]  <= 0;
                    bv[i][j]  <= 0;
                end
        end else if (pe_en) begin
            for (int i = 0; i < W; i++)
                for (int j = 0; j < H; j++) begin
                    ain = (j == 0) ? int'(a_feed[i]) : ah[i][j - 1];
                    bin = (i == 0) ? int'(b_feed[j]) : bv[i - 1][j];
                    acc[i][j] <= acc[i][j] + ain * bin;
                    ah[i][j]  <= ain;
                    bv[i][j]  <= bin;
                end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int nd;
        int bad;

        // reset held with start high
        reset_n = 1'b0;
        start   = 1'b1;
        tick(3);
        chk("rst_outs", 64'({|a_feed, |b_feed, pe_clear, pe_en, busy, done}), 64'd0);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        start   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("rst_idle_busy", 64'(busy), 64'd0);
        end

        // skew pattern
        load_skew();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("c1_clear", 64'({pe_clear, pe_en}), 64'b10);
        tick(1);
        chk("t0_a", 64'(a_feed), 64'h01_00_00_00_00);
        chk("t0_b", 64'(b_feed), 64'h01_00_00_00_00);
        tick(1);
        chk("t1_a", 64'(a_feed), 64'h02_0B_00_00_00);
        chk("t1_b", 64'(b_feed), 64'h0B_02_00_00_00);
        tick(1);
        chk("t2_a", 64'(a_feed), 64'h00_0C_15_00_00);
        tick(4);
        for (int c = 8; c <= 11; c++) begin
            chk("t6_9_zero", 64'({|a_feed, |b_feed}), 64'd0);
            tick(1);
        end
        chk("c12_done", 64'(done), 64'd1);
        tick(2);

        // operand isolation and ignored start during FEED
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        matrix_a = '1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("iso_t5_a", 64'(a_feed), 64'h00_00_00_00_2A);
        nd = 0;
        for (int c = 0; c < 24; c++) begin
            if (done) nd++;
            tick(1);
        end
        chk("iso_one_done", 64'(nd), 64'd1);
        chk("iso_idle", 64'(busy), 64'd0);

        // back-to-back runs with start held
        load_skew();
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            chk("b2b_done", 64'(done), 64'(c == 12 || c == 25 || c == 38));
            chk("b2b_busy", 64'(busy), 64'(!(c == 13 || c == 26 || c == 39)));
        end
        start = 1'b0;
        wait_done(ok);
        chk("b2b_tail_done", 64'(ok), 64'd1);
        tick(2);

        // reset in the middle of FEED
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_outs", 64'({|a_feed, |b_feed, pe_clear, pe_en, busy, done}), 64'd0);
        reset_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (done) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("rerun_t0_a", 64'(a_feed), 64'h01_00_00_00_00);
        tick(10);
        chk("rerun_done", 64'(done), 64'd1);
        tick(2);

        // end-to-end against a behavioural MAC grid
        bad = 0;
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < W; i++)
                for (int k = 0; k < L; k++)
                    matrix_a[i][k] = DW'($urandom_range(0, 255));
            for (int k = 0; k < L; k++)
                for (int j = 0; j < H; j++)
                    matrix_b[k][j] = DW'($urandom_range(0, 255));
            start = 1'b1;
            tick(1);
            start = 1'b0;
            wait_done(ok);
            chk("e2e_done", 64'(ok), 64'd1);
            bad = 0;
            for (int i = 0; i < W; i++)
                for (int j = 0; j < H; j++) begin
                    int ref_c;
                    ref_c = 0;
                    for (int k = 0; k < L; k++)
                        ref_c += int'(matrix_a[i][k]) * int'(matrix_b[k][j]);
                    if (acc[i][j] != ref_c && bad == 0) begin
                        bad = 1;
                        chk("e2e_acc", 64'(acc[i][j]), 64'(ref_c));
                    end
                end
            if (bad == 0) chk("e2e_acc", 64'(acc[W - 1][H - 1]),
                              64'(acc[W - 1][H - 1]));
            tick(1);
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer that drives one matrix multiplication C = A·B through the output-stationary systolic array. On `start` it latches matrix A (ARRAY_W×ARRAY_L, from the A ROM) and matrix B (ARRAY_L×ARRAY_H). It clears the PE accumulators, then feeds A rows into the left edge and B columns into the top edge with the diagonal skew the array needs. It signals `done` when the last product has reached the far-corner PE. It sits between the operand ROMs and the PE grid.

## Interface
- DATA_WIDTH, 8, operand element width
- ARRAY_W, 5, PE rows = rows of A
- ARRAY_L, 2, inner dimension = columns of A = rows of B
- ARRAY_H, 5, PE columns = columns of B

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- matrix_a  in  [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  A operand, element [i][k]
- matrix_b  in  [0:ARRAY_L-1][0:ARRAY_H-1][DATA_WIDTH-1:0]  B operand, element [k][j]
- a_feed  out  [0:ARRAY_W-1][DATA_WIDTH-1:0]  left-edge input of PE row i
- b_feed  out  [0:ARRAY_H-1][DATA_WIDTH-1:0]  top-edge input of PE column j
- pe_clear  out  1  zero all PE accumulators
- pe_en  out  1  PE shift/accumulate enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- **States and transitions:** IDLE → CLEAR → FEED → DONE → IDLE.
- **IDLE:**
  - Exits to CLEAR when `start`=1 at a rising edge.
  - `matrix_a` and `matrix_b` are copied into internal registers on that same edge.
- **CLEAR:** lasts 1 cycle. `pe_clear`=1 and `pe_en`=0.
- **FEED:**
  - Lasts N = ARRAY_L+ARRAY_W+ARRAY_H−2 cycles. The step counter t runs 0..N−1, starting at 0 on the first FEED cycle.
  - `pe_en`=1 on every FEED cycle.
  - `a_feed[i]` = A_latched[i][t−i] when 0 ≤ t−i ≤ ARRAY_L−1, otherwise 0.
  - `b_feed[j]` = B_latched[t−j][j] when 0 ≤ t−j ≤ ARRAY_L−1, otherwise 0.
  - The index arithmetic is unsigned-safe: a negative t−i selects 0 and never wraps to a valid element.
  - The step counter width is $clog2(N+1).
- **DONE:** lasts 1 cycle. `done`=1, `pe_en`=0. The next state is always IDLE.
- **Feed outputs:**
  - `a_feed`/`b_feed` are decoded from the registered state, step counter and latched matrices.
  - They are 0 in every state except FEED.
- **Operand isolation:** changes on `matrix_a`/`matrix_b` after the start edge have no effect until the next accepted start.
- **Start outside IDLE:** `start` is ignored in CLEAR, FEED and DONE. It is not queued. If `start` is still high in the following IDLE cycle, it is accepted there.
- **Reset (`reset_n`=0 at any edge, mid-run included):**
  - Next state is IDLE and the step counter is 0.
  - All outputs are 0: `a_feed`, `b_feed`, `pe_clear`, `pe_en`, `busy`, `done`.
  - No `done` is issued for an aborted run. The latched matrices are cleared to 0.

## Timing
- Cycle numbering: cycle 0 is the edge at which `start` is accepted.
- Cycle 1 is CLEAR. Cycles 2..N+1 are FEED with t = cycle−2. Cycle N+2 is DONE. Cycle N+3 is IDLE.
- With the defaults N=10: FEED covers cycles 2..11 and `done` is high in cycle 12.
- `busy` rises in cycle 1 and falls in cycle N+3.
- With `start` held high, the next run starts at cycle N+3, giving a period of N+3 = 13 cycles.
- The last nonzero feed is at t = ARRAY_L+max(ARRAY_W,ARRAY_H)−2. The remaining steps flush the skew so that A[W−1][L−1]·B[L−1][H−1] is accumulated in PE(W−1,H−1) at t=N−1.
- Degenerate sizes: ARRAY_L=1 is legal. ARRAY_W=ARRAY_H=ARRAY_L=1 gives N=1.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `start`=1 → all outputs 0, state IDLE. Release with `start`=0 → `busy` stays 0.
- **Skew pattern:** A[i][k]=10i+k+1, B[k][j]=10k+j+1, single-cycle `start` →
  - cycle 1: `pe_clear`=1.
  - t=0: `a_feed`={1,0,0,0,0}, `b_feed`={1,0,0,0,0}.
  - t=1: `a_feed`={2,11,0,0,0}, `b_feed`={11,2,0,0,0}.
  - t=2: `a_feed`={0,12,21,0,0}.
  - t=6..9: all feeds 0.
  - cycle 12: `done`=1.
- **Operand isolation and ignored start:** change `matrix_a` to all 0xFF and pulse `start` during FEED step 4 → feeds still follow the original A, with no restart and no extra `done`.
- **Back-to-back runs:** hold `start`=1 for 40 cycles → `done` in cycles 12, 25 and 38; `busy` low exactly in cycles 13, 26 and 39.
- **Reset mid-run:** `reset_n`=0 at FEED t=5 → next cycle all outputs 0 and no `done`. A new `start` then gives a full, correct run.
- **End-to-end:** connect to a behavioural 5×5 MAC grid with random 8-bit A and B → accumulators after `done` equal the reference product C for 100 random matrices.
